deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Receive-side stage that sits directly downstream of the serializer and consumes its serial output stream.
- Collects MSB-first serial bits into a parallel word.
- Emits a frame when DATA_BUS_WIDTH bits have arrived, or when the valid strobe drops mid-frame.
- Reports the number of valid bits using the same modulus encoding the serializer accepts, so a serializer→deserializer loop reproduces the original data and data_mod.

Parameters:
- DATA_BUS_WIDTH, 16, parallel word width; must be ≥4.
- DATA_MOD_WIDTH, $clog2(DATA_BUS_WIDTH), width of the bit-count field; value 0 encodes a full word.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- ser_data_i  input  1  serial data bit, MSB of the frame first.
- ser_data_val_i  input  1  qualifies ser_data_i; stays high for the whole frame.
- deser_data_o  output  DATA_BUS_WIDTH  assembled word, left-aligned; unused LSBs are 0.
- deser_data_mod_o  output  DATA_MOD_WIDTH  valid bit count; 0 means DATA_BUS_WIDTH bits.
- deser_data_val_o  output  1  one-cycle strobe qualifying deser_data_o and deser_data_mod_o.
- runt_o  output  1  one-cycle strobe: a frame shorter than 3 bits was dropped.

Behaviour:
- Reset (rst_n_i=0, async): state=IDLE_S, bit counter=0, shift buffer=0, all outputs 0. Any partial frame is discarded with no strobe.
- States: IDLE_S, COLLECT_S.
- IDLE_S:
  - ser_data_val_i=1: store bit at buffer[W-1], cnt=1, go to COLLECT_S.
  - Otherwise hold.
- COLLECT_S, ser_data_val_i=1:
  - Store bit at buffer[W-1-cnt], cnt=cnt+1.
  - If this is the W-th bit: register output with data=buffer incl. this bit, mod=0, val=1 at this same edge. Clear buffer/cnt.
  - Stay in COLLECT_S (next cycle may start a new frame back-to-back) or go to IDLE_S; both are allowed, but the next bit must be accepted with no lost cycle.
- COLLECT_S, ser_data_val_i=0 (gap), cnt≥3:
  - Register output with data=buffer, mod=cnt[DATA_MOD_WIDTH-1:0], val=1.
  - Clear buffer/cnt, go to IDLE_S.
- COLLECT_S, ser_data_val_i=0, cnt∈{1,2}:
  - No data strobe; runt_o=1 for one cycle.
  - Clear, go to IDLE_S.
- Latency:
  - Full word: deser_data_val_o high in the cycle right after the edge that sampled the last bit.
  - Partial word: high in the cycle after the edge that sampled the first ser_data_val_i=0.
- deser_data_o and deser_data_mod_o hold their last value when val=0; they change only when a strobe occurs.
- Counter needs $clog2(W)+1 bits internally. Full-word detection uses cnt==W-1 before the increment, so there is no wrap ambiguity.
- No backpressure: the serial stream cannot stall. Downstream must accept every strobe.
- Buffer bits not yet written are 0, so partial outputs have zero LSBs.
- Full-word completion followed by ser_data_val_i=0: no extra strobe, because cnt=0 on the gap.

Decomposition:
- Package ser_pkg:
  - deser_state_t enum {IDLE_S, COLLECT_S}.
  - Constant MIN_FRAME_LEN=3, shared with the serializer's small-size rejection.
- No sub-module. Single file: FSM, counter, buffer, output registers.

Test Plan:
- Full word, W=16: 16 bits of 0xA5C3 MSB-first, val high 16 cycles → one strobe, data=0xA5C3, mod=0, 1 cycle after last bit.
- Partial frame: 5 bits 1,0,1,1,0 then val=0 → data=0xB000, mod=5, strobe in the cycle after the gap edge; runt_o=0.
- Back-to-back: 32 consecutive valid bits 0x1234 then 0xFFFF → two strobes exactly 16 cycles apart, values 0x1234 and 0xFFFF, mod=0 each.
- Runt: 2 valid bits then gap → runt_o pulses once; deser_data_val_o stays 0; next 3-bit frame 1,1,1 → data=0xE000, mod=3.
- Async reset mid-frame: assert rst_n_i between clock edges after 7 bits → outputs 0 immediately. After release, a 16-bit frame 0x0F0F arrives intact with no stale bits.
- Loopback with the serializer: random data/mod over 1000 frames (mod 1 and 2 excluded) → data (masked to mod bits) and mod match the inputs exactly.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and constants for the serial link (serializer and deserializer).
// The minimum frame length also sets the serializer's small-size rejection threshold.
package ser_pkg;

   typedef enum logic {
      IDLE_S    = 1'b0,
      COLLECT_S = 1'b1
   } deser_state_t;

   localparam int MIN_FRAME_LEN = 3;

endpackage

// File: rtl/deserializer.sv
// Collects an MSB-first serial stream into left-aligned parallel words.
// A frame ends on the W-th bit or on a gap; frames shorter than MIN_FRAME_LEN raise runt_o.
module deserializer
   import ser_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = 16,
   parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      ser_data_i,
   input  logic                      ser_data_val_i,
   output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
   output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
   output logic                      deser_data_val_o,
   output logic                      runt_o,
   output deser_state_t              dbg_state_o
);

   localparam int W  = DATA_BUS_WIDTH;
   localparam int MW = DATA_MOD_WIDTH;
   localparam int CW = $clog2(DATA_BUS_WIDTH) + 1;

   deser_state_t  r_state;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_buf;
   logic [W-1:0]  r_data;
   logic [MW-1:0] r_mod;
   logic          r_val;
   logic          r_runt;

   logic [MW-1:0] w_idx;
   logic          w_word_done;
   logic          w_long_enough;

   // Counter is always below W while collecting, so the low MW bits index the buffer safely.
   assign w_idx         = MW'(W - 1) - r_cnt[MW-1:0];
   assign w_word_done   = (r_cnt == CW'(W - 1));
   assign w_long_enough = (r_cnt >= CW'(MIN_FRAME_LEN));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE_S;
         r_cnt   <= '0;
         r_buf   <= '0;
         r_data  <= '0;
         r_mod   <= '0;
         r_val   <= 1'b0;
         r_runt  <= 1'b0;
      end else begin
         r_val  <= 1'b0;
         r_runt <= 1'b0;
         case (r_state)
            IDLE_S: begin
               if (ser_data_val_i) begin
                  r_buf   <= {ser_data_i, {(W-1){1'b0}}};
                  r_cnt   <= CW'(1);
                  r_state <= COLLECT_S;
               end
            end
            COLLECT_S: begin
               if (ser_data_val_i) begin
                  if (w_word_done) begin
                     // Stay in COLLECT_S with cnt=0 so a back-to-back frame loses no cycle.
                     r_data <= {r_buf[W-1:1], ser_data_i};
                     r_mod  <= '0;
                     r_val  <= 1'b1;
                     r_buf  <= '0;
                     r_cnt  <= '0;
                  end else begin
                     r_buf[w_idx] <= ser_data_i;
                     r_cnt        <= r_cnt + CW'(1);
                  end
               end else begin
                  if (w_long_enough) begin
                     r_data <= r_buf;
                     r_mod  <= r_cnt[MW-1:0];
                     r_val  <= 1'b1;
                  end else if (r_cnt != '0) begin
                     r_runt <= 1'b1;
                  end
                  r_buf   <= '0;
                  r_cnt   <= '0;
                  r_state <= IDLE_S;
               end
            end
            default: begin
               r_buf   <= '0;
               r_cnt   <= '0;
               r_state <= IDLE_S;
            end
         endcase
      end
   end

   assign deser_data_o     = r_data;
   assign deser_data_mod_o = r_mod;
   assign deser_data_val_o = r_val;
   assign runt_o           = r_runt;
   assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_deserializer.sv
// Randomized scoreboard bench for the deserializer: frames are built from whole words and
// expected outputs (value, bit count, arrival cycle) are derived from the word and its length.
module tb_deserializer;
   import ser_pkg::*;

   localparam int W  = 16;
   localparam int MW = $clog2(W);
   localparam int EW = 1 + W + MW + 32;

   logic          clk;
   logic          rst_n;
   logic          ser_data;
   logic          ser_val;
   logic [W-1:0]  deser_data;
   logic [MW-1:0] deser_mod;
   logic          deser_val;
   logic          runt;
   deser_state_t  dbg_state;

   int checks;
   int errors;
   int cyc;

   // Entry layout: {runt, data, mod, due_cycle}
   logic [EW-1:0] exp_q[$];
   logic [W-1:0]  hold_data;
   logic [MW-1:0] hold_mod;

   deserializer #(.DATA_BUS_WIDTH(W)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .ser_data_i       (ser_data),
      .ser_data_val_i   (ser_val),
      .deser_data_o     (deser_data),
      .deser_data_mod_o (deser_mod),
      .deser_data_val_o (deser_val),
      .runt_o           (runt),
      .dbg_state_o      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver tasks ----------------
   task automatic push_exp(input logic is_runt, input logic [W-1:0] d, input logic [MW-1:0] m);
      logic [31:0] due;
      due = 32'(cyc + 1);
      exp_q.push_back({is_runt, d, m, due});
   endtask

   task automatic send_frame(input logic [W-1:0] word, input int n, input bit gap);
      logic [W-1:0] exp_w;
      exp_w = (n >= W) ? word : ((word >> (W - n)) << (W - n));
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ser_val  = 1'b1;
         ser_data = word[W-1-i];
         if (i == n - 1 && n == W) push_exp(1'b0, exp_w, '0);
      end
      if (gap) begin
         @(negedge clk);
         ser_val  = 1'b0;
         ser_data = 1'($urandom_range(0, 1));
         if (n < W && n >= MIN_FRAME_LEN) push_exp(1'b0, exp_w, MW'(n));
         else if (n > 0 && n < MIN_FRAME_LEN) push_exp(1'b1, '0, '0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ser_val  = 1'b0;
         ser_data = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (deser_data !== '0 || deser_mod !== '0 || deser_val !== 1'b0 || runt !== 1'b0) begin
         errors++;
         $display("FAIL %s: data=%h mod=%0d val=%b runt=%b, required all zero",
                  name, deser_data, deser_mod, deser_val, runt);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (deser_val || runt) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: val=%b runt=%b data=%h mod=%0d at cycle %0d, required no strobe",
                        deser_val, runt, deser_data, deser_mod, cyc);
            end else begin
               logic [EW-1:0] e;
               logic          e_runt;
               logic [W-1:0]  e_data;
               logic [MW-1:0] e_mod;
               logic [31:0]   e_due;
               e      = exp_q.pop_front();
               e_due  = e[31:0];
               e_mod  = e[32 +: MW];
               e_data = e[32+MW +: W];
               e_runt = e[32+MW+W];
               if (e_runt) begin
                  if (runt !== 1'b1 || deser_val !== 1'b0 || 32'(cyc) !== e_due) begin
                     errors++;
                     $display("FAIL runt_strobe: runt=%b val=%b cycle=%0d, required runt=1 val=0 cycle=%0d",
                              runt, deser_val, cyc, e_due);
                  end
               end else begin
                  if (deser_val !== 1'b1 || runt !== 1'b0 || deser_data !== e_data ||
                      deser_mod !== e_mod || 32'(cyc) !== e_due) begin
                     errors++;
                     $display("FAIL data_strobe: val=%b runt=%b data=%h mod=%0d cycle=%0d, required val=1 runt=0 data=%h mod=%0d cycle=%0d",
                              deser_val, runt, deser_data, deser_mod, cyc, e_data, e_mod, e_due);
                  end
                  hold_data <= e_data;
                  hold_mod  <= e_mod;
               end
            end
         end else begin
            checks++;
            if (deser_data !== hold_data || deser_mod !== hold_mod) begin
               errors++;
               $display("FAIL output_hold: data=%h mod=%0d at cycle %0d, required data=%h mod=%0d",
                        deser_data, deser_mod, cyc, hold_data, hold_mod);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] word;
      int           n;
      hold_data = '0;
      hold_mod  = '0;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      ser_val   = 1'b0;
      ser_data  = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Directed cases
      send_frame(16'hA5C3, 16, 1'b1);
      idle(2);
      send_frame(16'hB000, 5, 1'b1);
      idle(1);
      send_frame(16'h1234, 16, 1'b0);
      send_frame(16'hFFFF, 16, 1'b1);
      idle(2);
      send_frame(16'hC000, 2, 1'b1);
      idle(1);
      send_frame(16'hE000, 3, 1'b1);
      idle(2);
      send_frame(16'h8000, 1, 1'b1);
      send_frame(16'h6000, 15, 1'b1);
      idle(2);

      // Async reset in the middle of a 7-bit partial frame
      send_frame(16'hFE00, 7, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      hold_data = '0;
      hold_mod  = '0;
      #1 check_zero("async_reset_mid_frame");
      @(negedge clk);
      ser_val = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      send_frame(16'h0F0F, 16, 1'b1);
      idle(2);

      // Randomized loopback-style frames
      for (int f = 0; f < 1000; f++) begin
         word = W'($urandom());
         n    = $urandom_range(MIN_FRAME_LEN, W);
         if ($urandom_range(0, 19) == 0) n = $urandom_range(1, MIN_FRAME_LEN - 1);
         if (n < W) send_frame(word, n, 1'b1);
         else       send_frame(word, n, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(2);

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected strobes never arrived, required 0", exp_q.size());
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
